// File: rtl/calc_sequencer.sv
// Calculator front-end sequencer: gathers A, B and opcode from the keypad,
// strobes the operand/opcode registers, launches the ALU and waits for it with a timeout.
module calc_sequencer #(
    parameter int Word_Length    = 4,
    parameter int NUM_OPS        = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start_i,
    input  logic                   abort_i,
    input  logic                   clear_i,
    input  logic                   key_valid_i,
    input  logic [Word_Length-1:0] key_data_i,
    input  logic                   alu_done_i,
    output logic [Word_Length-1:0] reg_data_o,
    output logic                   ld_a_o,
    output logic                   ld_b_o,
    output logic                   ld_op_o,
    output logic                   alu_start_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   error_o,
    output logic [2:0]             state_o
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        GET_A  = 3'd1,
        GET_B  = 3'd2,
        GET_OP = 3'd3,
        EXEC   = 3'd4,
        WAIT   = 3'd5,
        DONE   = 3'd6,
        ERR    = 3'd7
    } state_t;

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0]        CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [Word_Length:0] OPS_LIM  = (Word_Length + 1)'(NUM_OPS);

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [Word_Length-1:0] reg_data_q, reg_data_d;
    logic                   ld_a_q, ld_a_d, ld_b_q, ld_b_d, ld_op_q, ld_op_d;
    logic                   alu_start_q, alu_start_d, done_q, done_d, error_q, error_d;
    logic                   busy_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        reg_data_d  = reg_data_q;
        ld_a_d      = 1'b0;
        ld_b_d      = 1'b0;
        ld_op_d     = 1'b0;
        alu_start_d = 1'b0;
        done_d      = 1'b0;
        error_d     = error_q;
        case (state_q)
            IDLE: if (start_i) state_d = GET_A;
            GET_A: begin
                if (abort_i) state_d = IDLE;
                else if (key_valid_i) begin
                    reg_data_d = key_data_i;
                    ld_a_d     = 1'b1;
                    state_d    = GET_B;
                end
            end
            GET_B: begin
                if (abort_i) state_d = IDLE;
                else if (key_valid_i) begin
                    reg_data_d = key_data_i;
                    ld_b_d     = 1'b1;
                    state_d    = GET_OP;
                end
            end
            GET_OP: begin
                if (abort_i) state_d = IDLE;
                else if (key_valid_i) begin
                    // An illegal opcode is not latched; the bus keeps operand B.
                    if ({1'b0, key_data_i} < OPS_LIM) begin
                        reg_data_d = key_data_i;
                        ld_op_d    = 1'b1;
                        state_d    = EXEC;
                    end else begin
                        error_d = 1'b1;
                        state_d = ERR;
                    end
                end
            end
            EXEC: begin
                if (abort_i) state_d = IDLE;
                else begin
                    alu_start_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                // alu_done is checked before the timeout so a same-cycle collision completes.
                if (abort_i) state_d = IDLE;
                else if (alu_done_i) begin
                    done_d  = 1'b1;
                    state_d = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    error_d = 1'b1;
                    state_d = ERR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: state_d = IDLE;
            ERR: begin
                if (clear_i) begin
                    error_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            reg_data_q  <= '0;
            ld_a_q      <= 1'b0;
            ld_b_q      <= 1'b0;
            ld_op_q     <= 1'b0;
            alu_start_q <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            reg_data_q  <= reg_data_d;
            ld_a_q      <= ld_a_d;
            ld_b_q      <= ld_b_d;
            ld_op_q     <= ld_op_d;
            alu_start_q <= alu_start_d;
            done_q      <= done_d;
            error_q     <= error_d;
            busy_q      <= (state_d != IDLE) && (state_d != DONE) && (state_d != ERR);
        end
    end

    assign reg_data_o  = reg_data_q;
    assign ld_a_o      = ld_a_q;
    assign ld_b_o      = ld_b_q;
    assign ld_op_o     = ld_op_q;
    assign alu_start_o = alu_start_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign error_o     = error_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Scoreboard bench for calc_sequencer: stimulus queues expected strobe events,
// a negedge monitor pops and compares them as the DUT emits them.
module tb_calc_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0, abort = 1'b0, clear = 1'b0;
    logic       key_valid = 1'b0, alu_done = 1'b0;
    logic [3:0] key_data = 4'd0;
    logic [3:0] reg_data;
    logic       ld_a, ld_b, ld_op, alu_start, busy, done, error;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int kind;
        int data;
    } ev_t;
    ev_t exp_q[$];
    logic err_prev = 1'b0;

    // kinds: 0 ld_a, 1 ld_b, 2 ld_op, 3 alu_start, 4 done, 5 error rising (data = state)
    calc_sequencer #(.Word_Length(4), .NUM_OPS(4), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset), .start_i(start), .abort_i(abort), .clear_i(clear),
        .key_valid_i(key_valid), .key_data_i(key_data), .alu_done_i(alu_done),
        .reg_data_o(reg_data), .ld_a_o(ld_a), .ld_b_o(ld_b), .ld_op_o(ld_op),
        .alu_start_o(alu_start), .busy_o(busy), .done_o(done), .error_o(error),
        .state_o(state)
    );

    always #5 clk = ~clk;

    task automatic push(input int k, input int d);
        ev_t e;
        e.kind = k;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic got(input int k, input int d);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL event: unexpected kind=%0d data=%0d at %0t", k, d, $time);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.data != d) begin
                errors++;
                $display("FAIL event: got kind=%0d data=%0d, expected kind=%0d data=%0d at %0t",
                         k, d, e.kind, e.data, $time);
            end
        end
    endtask

    always @(negedge clk) begin
        if (ld_a)      got(0, int'(reg_data));
        if (ld_b)      got(1, int'(reg_data));
        if (ld_op)     got(2, int'(reg_data));
        if (alu_start) got(3, 0);
        if (done)      got(4, 0);
        if (error && !err_prev) got(5, int'(state));
        err_prev <= error;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic key(input logic [3:0] k);
        key_valid = 1'b1;
        key_data  = k;
        tick();
        key_valid = 1'b0;
    endtask

    // From IDLE: start and enter three legal keys; ends in WAIT with alu_start visible.
    task automatic run_to_wait(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("enter_get_a", state, 1);
        push(0, a); key(a);
        push(1, b); key(b);
        push(2, op); key(op);
        chk("enter_exec", state, 4);
        push(3, 0); tick();
        chk("enter_wait", state, 5);
    endtask

    initial begin
        #12;
        chk("reset_state", state, 0);
        chk("reset_outs", {reg_data, ld_a, ld_b, ld_op, alu_start, busy, done, error}, 0);
        reset = 1'b1;
        tick();

        // normal operation, alu_done 3 cycles after alu_start
        run_to_wait(4'h5, 4'h3, 4'h2);
        chk("wait_busy", busy, 1);
        tick(3);
        alu_done = 1'b1;
        push(4, 0); tick();
        alu_done = 1'b0;
        chk("normal_done_state", state, 6);
        chk("done_not_busy", busy, 0);
        tick();
        chk("normal_idle", state, 0);
        chk("idle_busy", busy, 0);
        chk("reg_data_hold", reg_data, 2);

        // illegal opcode
        start = 1'b1; tick(); start = 1'b0;
        push(0, 1); key(4'h1);
        push(1, 1); key(4'h1);
        push(5, 7); key(4'h9);
        chk("illegal_state", state, 7);
        chk("illegal_error", error, 1);
        start = 1'b1; abort = 1'b1; key_valid = 1'b1;
        tick(3);
        start = 1'b0; abort = 1'b0; key_valid = 1'b0;
        chk("err_held_state", state, 7);
        chk("err_held_error", error, 1);
        clear = 1'b1; tick(); clear = 1'b0;
        chk("clear_state", state, 0);
        chk("clear_error", error, 0);

        // timeout: exactly 16 WAIT cycles
        run_to_wait(4'h7, 4'h4, 4'h3);
        tick(15);
        chk("w15_state", state, 5);
        chk("w15_error", error, 0);
        push(5, 7); tick();
        chk("timeout_state", state, 7);
        chk("timeout_error", error, 1);
        clear = 1'b1; tick(); clear = 1'b0;
        chk("timeout_clear", state, 0);

        // done/timeout collision on the 16th WAIT cycle
        run_to_wait(4'h2, 4'h2, 4'h0);
        tick(15);
        alu_done = 1'b1;
        push(4, 0); tick();
        alu_done = 1'b0;
        chk("collide_state", state, 6);
        chk("collide_error", error, 0);
        tick();

        // abort with key in GET_B, then keys ignored in IDLE
        start = 1'b1; tick(); start = 1'b0;
        push(0, 4); key(4'h4);
        abort = 1'b1; key_valid = 1'b1; key_data = 4'h6;
        tick();
        abort = 1'b0; key_valid = 1'b0;
        chk("abort_state", state, 0);
        chk("abort_reg_data", reg_data, 4);
        key_valid = 1'b1; key_data = 4'hA;
        tick(3);
        key_valid = 1'b0;
        chk("idle_keys_state", state, 0);

        // async reset between edges while in WAIT
        run_to_wait(4'h1, 4'h2, 4'h3);
        tick(2);
        #2 reset = 1'b0;
        #1;
        chk("async_state", state, 0);
        chk("async_outs", {reg_data, ld_a, ld_b, ld_op, alu_start, busy, done, error}, 0);
        @(negedge clk);
        reset = 1'b1;
        tick();

        // start held high: one op per IDLE visit
        start = 1'b1;
        tick();
        chk("held_get_a", state, 1);
        push(0, 9); key(4'h9);
        push(1, 8); key(4'h8);
        push(2, 1); key(4'h1);
        push(3, 0); tick();
        alu_done = 1'b1;
        push(4, 0); tick();
        alu_done = 1'b0;
        chk("held_done", state, 6);
        tick();
        chk("held_idle", state, 0);
        tick();
        chk("held_rearm", state, 1);
        start = 1'b0;
        abort = 1'b1; tick(); abort = 1'b0;
        chk("held_abort", state, 0);

        tick(2);
        chk("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
